// File: rtl/tia_biphase_clock_decoder.sv
// tia_biphase_clock_decoder: checks the phi1/phi2 non-overlapping sequence and emits phase pulses, cycle count and a sticky fault.
module tia_biphase_clock_decoder #(
    parameter int MAX_HOLD = 4,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          r,
    input  logic          phi1,
    input  logic          phi2,
    input  logic          rl,
    output logic          p1_tick,
    output logic          p2_tick,
    output logic          cycle_done,
    output logic [CW-1:0] cycles,
    output logic          in_sync,
    output logic          err,
    output logic [1:0]    err_code
);
    typedef enum logic [2:0] {IDLE, SYNC, PHI1, Z1, PHI2, Z2, FAULT} state_t;
    localparam int HW = $clog2(MAX_HOLD + 1);
    state_t state, adv;
    logic [HW-1:0] hold;
    logic [1:0] s, stay_lvl, go_lvl, f_code;
    assign s = {phi1, phi2};
    // Level that keeps the current phase, level that advances it, and where it advances to.
    always_comb begin
        stay_lvl = (state == PHI1) ? 2'b10 : (state == PHI2) ? 2'b01 : 2'b00;
        go_lvl = (state == PHI1 || state == PHI2) ? 2'b00 : (state == Z1) ? 2'b01 : 2'b10;
        adv = (state == PHI1) ? Z1 : (state == Z1) ? PHI2 : (state == PHI2) ? Z2 : PHI1;
        f_code = (state == IDLE || state == FAULT) ? 2'd0 :
                 (s == 2'b11) ? 2'd1 :
                 (rl || state == SYNC || s == go_lvl) ? 2'd0 :
                 (s != stay_lvl) ? 2'd2 :
                 (hold == HW'(MAX_HOLD - 1)) ? 2'd3 : 2'd0;
    end
    always_ff @(posedge clk) begin
        if (r) begin
            state <= IDLE;
            hold <= '0;
            cycles <= '0;
            p1_tick <= 1'b0;
            p2_tick <= 1'b0;
            cycle_done <= 1'b0;
            in_sync <= 1'b0;
            err <= 1'b0;
            err_code <= 2'd0;
        end else begin
            p1_tick <= 1'b0;
            p2_tick <= 1'b0;
            cycle_done <= 1'b0;
            if (state != FAULT) begin
                if (f_code != 2'd0) begin
                    state <= FAULT;
                    err <= 1'b1;
                    err_code <= f_code;
                    in_sync <= 1'b0;
                    hold <= '0;
                end else if (state == IDLE) begin
                    if (!rl) state <= SYNC;
                end else if (rl) begin
                    state <= IDLE;
                    in_sync <= 1'b0;
                    hold <= '0;
                end else if (state == SYNC) begin
                    if (s == 2'b10) begin
                        state <= PHI1;
                        p1_tick <= 1'b1;
                        in_sync <= 1'b1;
                    end
                end else if (s == go_lvl) begin
                    state <= adv;
                    hold <= '0;
                    p1_tick <= adv == PHI1;
                    p2_tick <= adv == PHI2;
                    cycle_done <= adv == PHI1;
                    if (adv == PHI1) cycles <= cycles + 1'b1;
                end else begin
                    hold <= hold + 1'b1;
                end
            end
        end
    end
endmodule
